// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button edge detection, run/pause/lap sequencing and tick prescaler.
// Define STOPWATCH_AUTOSTOP_EN to stop the count at the terminal value instead of wrapping.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  input  logic       at_max,
  output logic       tick_en,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic [1:0] state,
  output logic       at_limit
);

  localparam logic [1:0] StIdle  = 2'b00;
  localparam logic [1:0] StRun   = 2'b01;
  localparam logic [1:0] StPause = 2'b10;
  localparam logic [1:0] StLap   = 2'b11;

  localparam logic [15:0] PrescMax = 16'(TICK_DIV - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic        ss_q, lap_q, clr_q;
  logic        armed_q;
  logic        tick_q, tick_d;
  logic        cnt_clr_q;
  logic        disp_hold_q;
  logic        ss_ev, lap_ev, clr_ev;
  logic        running, tick_due;
  logic        limit_hit, limit_lock;

  // armed_q stays low for the first cycle after reset so a button held through
  // reset release is absorbed into its history flop rather than seen as a rise.
  assign ss_ev  = armed_q & start_stop & ~ss_q;
  assign lap_ev = armed_q & lap & ~lap_q;
  assign clr_ev = armed_q & clear & ~clr_q;

  assign running  = (state_q == StRun) || (state_q == StLap);
  assign tick_due = running && (presc_q == PrescMax);

`ifdef STOPWATCH_AUTOSTOP_EN
  logic at_limit_q;

  assign limit_hit  = tick_due & at_max & ~clr_ev;
  assign limit_lock = at_limit_q;
  assign at_limit   = at_limit_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      at_limit_q <= 1'b0;
    end else if (clr_ev) begin
      at_limit_q <= 1'b0;
    end else if (limit_hit) begin
      at_limit_q <= 1'b1;
    end
  end
`else
  logic unused_at_max;

  assign unused_at_max = at_max;
  assign limit_hit     = 1'b0;
  assign limit_lock    = 1'b0;
  assign at_limit      = 1'b0;
`endif

  // Priority: clear, then auto-stop, then start_stop, then lap.
  always_comb begin
    state_d = state_q;
    if (clr_ev) begin
      state_d = StIdle;
    end else if (limit_hit) begin
      state_d = StPause;
    end else begin
      case (state_q)
        StIdle: begin
          if (ss_ev) state_d = StRun;
        end
        StRun: begin
          if (ss_ev)       state_d = StPause;
          else if (lap_ev) state_d = StLap;
        end
        StLap: begin
          if (ss_ev)       state_d = StPause;
          else if (lap_ev) state_d = StRun;
        end
        StPause: begin
          if (ss_ev && !limit_lock) state_d = StRun;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    presc_d = presc_q;
    if (clr_ev || (state_q == StIdle)) begin
      presc_d = '0;
    end else if (running) begin
      presc_d = (presc_q == PrescMax) ? '0 : presc_q + 16'd1;
    end
  end

  assign tick_d = tick_due & ~clr_ev & ~limit_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      ss_q        <= 1'b0;
      lap_q       <= 1'b0;
      clr_q       <= 1'b0;
      armed_q     <= 1'b0;
      tick_q      <= 1'b0;
      cnt_clr_q   <= 1'b0;
      disp_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      ss_q        <= start_stop;
      lap_q       <= lap;
      clr_q       <= clear;
      armed_q     <= 1'b1;
      tick_q      <= tick_d;
      cnt_clr_q   <= clr_ev;
      disp_hold_q <= (state_d == StLap);
    end
  end

  assign state     = state_q;
  assign tick_en   = tick_q;
  assign cnt_clr   = cnt_clr_q;
  assign disp_hold = disp_hold_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4; auto-stop checks follow STOPWATCH_AUTOSTOP_EN.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_stop, lap, clear, at_max;
  logic       tick_en, cnt_clr, disp_hold, at_limit;
  logic [1:0] state;

  int n_chk = 0;
  int n_bad = 0;
  int cnt;
  int first;

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .at_max     (at_max),
    .tick_en    (tick_en),
    .cnt_clr    (cnt_clr),
    .disp_hold  (disp_hold),
    .state      (state),
    .at_limit   (at_limit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int observed, input int expected);
    n_chk++;
    assert (observed === expected) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic press(input logic s, input logic l, input logic c);
    start_stop = s;
    lap        = l;
    clear      = c;
    step();
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".state"}, int'(state), 0);
    chk({tag, ".tick_en"}, int'(tick_en), 0);
    chk({tag, ".cnt_clr"}, int'(cnt_clr), 0);
    chk({tag, ".disp_hold"}, int'(disp_hold), 0);
    chk({tag, ".at_limit"}, int'(at_limit), 0);
  endtask

  initial begin
    reset = 1'b1; start_stop = 1'b0; lap = 1'b0; clear = 1'b0; at_max = 1'b0;
    steps(3);
    chk_all_zero("reset");
    reset = 1'b0;
    steps(2);
    chk_all_zero("post_reset");

    // Start: tick every 4 cycles, first one 4 cycles after state reads RUN.
    press(1, 0, 0);
    chk("start.state", int'(state), 1);
    chk("start.tick0", int'(tick_en), 0);
    cnt = 0; first = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (tick_en) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    chk("run.ticks_in_20", cnt, 5);
    chk("run.first_tick", first, 4);

    // Pause with prescaler at 3, hold 50 cycles, resume: tick one cycle later.
    steps(2);
    press(1, 0, 0);
    chk("pause.state", int'(state), 2);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tick_en) cnt++;
    end
    chk("pause.no_ticks", cnt, 0);
    press(1, 0, 0);
    chk("resume.state", int'(state), 1);
    chk("resume.r0_tick", int'(tick_en), 0);
    step();
    chk("resume.r1_tick", int'(tick_en), 1);

    // Lap hold: counting continues.
    step();
    press(0, 1, 0);
    chk("lap.state", int'(state), 3);
    chk("lap.disp_hold", int'(disp_hold), 1);
    chk("lap.l0_tick", int'(tick_en), 0);
    steps(2);
    chk("lap.l2_tick", int'(tick_en), 1);
    press(0, 1, 0);
    chk("unlap.state", int'(state), 1);
    chk("unlap.disp_hold", int'(disp_hold), 0);

    // Clear beats start_stop, pressed while a tick is due.
    steps(2);
    press(1, 0, 1);
    chk("clr.state", int'(state), 0);
    chk("clr.cnt_clr", int'(cnt_clr), 1);
    chk("clr.tick", int'(tick_en), 0);
    step();
    chk("clr.cnt_clr_1cyc", int'(cnt_clr), 0);
    chk("clr.tick_after", int'(tick_en), 0);
    chk("clr.state_after", int'(state), 0);

    // Clear while idle still pulses cnt_clr.
    press(0, 0, 1);
    chk("idle_clr.state", int'(state), 0);
    chk("idle_clr.cnt_clr", int'(cnt_clr), 1);
    step();
    chk("idle_clr.cnt_clr_1cyc", int'(cnt_clr), 0);

    // start_stop beats lap; lap ignored in PAUSE; resume keeps prescaler at 2.
    press(1, 0, 0);
    chk("p.state", int'(state), 1);
    step();
    press(1, 1, 0);
    chk("prio.state", int'(state), 2);
    chk("prio.disp_hold", int'(disp_hold), 0);
    step();
    press(0, 1, 0);
    chk("pause_lap.state", int'(state), 2);
    step();
    press(1, 0, 0);
    chk("s0.state", int'(state), 1);
    step();
    chk("s1.tick", int'(tick_en), 0);
    step();
    chk("s2.tick", int'(tick_en), 1);

    // Terminal value reached.
    at_max = 1'b1;
    steps(4);
`ifdef STOPWATCH_AUTOSTOP_EN
    chk("limit.tick", int'(tick_en), 0);
    chk("limit.state", int'(state), 2);
    chk("limit.at_limit", int'(at_limit), 1);
    step();
    press(1, 0, 0);
    chk("limit.ss_ignored", int'(state), 2);
    chk("limit.sticky", int'(at_limit), 1);
`else
    chk("wrap.tick", int'(tick_en), 1);
    chk("wrap.state", int'(state), 1);
    chk("wrap.at_limit", int'(at_limit), 0);
    step();
`endif
    at_max = 1'b0;
    step();
    press(0, 0, 1);
    chk("limit_clr.state", int'(state), 0);
    chk("limit_clr.at_limit", int'(at_limit), 0);
    chk("limit_clr.cnt_clr", int'(cnt_clr), 1);

    // Reset mid-run with start_stop held through release.
    step();
    press(1, 0, 0);
    steps(4);
    chk("pre_rst.tick", int'(tick_en), 1);
    start_stop = 1'b1;
    reset = 1'b1;
    #1;
    chk_all_zero("async_rst");
    steps(2);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (tick_en || cnt_clr || (state != 2'b00)) cnt++;
    end
    chk("held_btn.no_activity", cnt, 0);
    chk("held_btn.state", int'(state), 0);
    start_stop = 1'b0;
    step();
    start_stop = 1'b1;
    step();
    chk("retoggle.state", int'(state), 1);
    start_stop = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
